elevator_request_scheduler: RTL and testbench
=============================================

// Module: elevator_request_scheduler
// PURPOSE
//  Latches floor-call button pulses and sequences the elevator car controller with LOOK scheduling.
//  Keeps travelling in one direction while calls remain ahead, then reverses.
//  Drives target_floor/target_valid into the car FSM and times the door dwell at each served floor.
//  Sits between the ui_in button inputs and the car state machine; current floor feeds back from the car.
// PARAMETERS
//  NUM_FLOORS    10    number of served floors, 2..16; floors are 0..NUM_FLOORS-1
//  FLOOR_W       4     floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS
//  DWELL_CYCLES  1000  clk cycles door_open stays high at a served floor; >= 1
// PORTS
//  clk          in   1           clock
//  reset        in   1           asynchronous, active-high
//  req_pulse    in   NUM_FLOORS  call buttons, bit i = floor i; multi-hot allowed; level or pulse
//  car_floor    in   FLOOR_W     current floor reported by car controller
//  car_idle     in   1           car stationary (car FSM in its idle state)
//  target_floor out  FLOOR_W     floor the car must travel to; registered
//  target_valid out  1           target_floor is meaningful; registered
//  door_open    out  1           high during dwell; registered
//  dir_up       out  1           current sweep direction, 1 = up; registered
//  pending      out  NUM_FLOORS  outstanding-call bitmap; registered
// BEHAVIOUR
//  Reset (async, immediate): pending=0, state=IDLE, dwell counter=0.
//   target_floor=0, target_valid=0, door_open=0, dir_up=1.
//  Latching: every cycle pending_next = (pending | req_pulse) & ~clear_mask.
//   clear_mask = one-hot(car_floor) while state==DWELL, else 0.
//   Clear wins over a simultaneous set for that floor. A new call at the car floor during dwell is absorbed.
//  Lookups: above = lowest pending floor > car_floor. below = highest pending floor < car_floor.
//  States (encoding in package):
//   IDLE: target_valid=0.
//    If pending[car_floor] -> DWELL.
//    Else if any above -> SERVE_UP, dir_up=1.
//    Else if any below -> SERVE_DOWN, dir_up=0.
//    Otherwise stay. Up has priority when calls lie on both sides.
//   SERVE_UP: target_floor<=above, target_valid=1.
//    A nearer call appearing ahead retargets next cycle.
//    If car_idle && car_floor==target_floor && target_valid -> DWELL.
//   SERVE_DOWN: mirror of SERVE_UP using below.
//   DWELL: target_valid=0, door_open=1, counter counts 0..DWELL_CYCLES-1.
//    On the last count: door_open=0.
//    Continue in dir_up if calls remain ahead, else reverse if calls behind, else IDLE.
//  Latency: req_pulse at cycle N -> pending at N+1 -> target_floor/target_valid at N+2.
//  car_floor >= NUM_FLOORS (illegal): treat as no match; never clear; hold state.
//  Calls behind the car in SERVE_UP/DOWN stay pending until the reversal.
//  target_floor always lies in 0..NUM_FLOORS-1.
//  Reset mid-travel or mid-dwell: all pending calls are lost.
// STRUCTURE
//  elevator_pkg: state encoding (IDLE/SERVE_UP/SERVE_DOWN/DWELL), FLOOR_W, NUM_FLOORS defaults.
//  Sub-module floor_select (combinational): pending + car_floor -> above/below index and found flags.
//  Top: pending register, FSM, dwell counter, output registers.
// TESTING (DWELL_CYCLES=4 for sim)
//  Reset, no calls -> target_valid=0, door_open=0, dir_up=1, pending=0 indefinitely.
//  car_floor=0, pulse floor 3 -> target_floor=3 two cycles later.
//   car_idle at 3 -> door_open 4 cycles, pending[3] clears, then IDLE.
//  car_floor=2 moving up to 7, pulse floor 5 -> retarget to 5.
//   Serve 5, then 7; pending floor 1 is served only after 7 (reversal, dir_up=0).
//  Pulse floors 1 and 6 in the same cycle at car_floor=3 -> SERVE_UP to 6 first (up priority).
//  During dwell at floor 4, re-pulse floor 4 -> pending[4] stays 0; dwell is not extended.
//  Assert reset mid-dwell with pending=0b0100100 -> all outputs and pending at reset values same cycle.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator request scheduler: FSM state encoding
// and default geometry/timing parameters.
package elevator_pkg;

    localparam int NUM_FLOORS_DEF   = 10;
    localparam int FLOOR_W_DEF      = 4;
    localparam int DWELL_CYCLES_DEF = 1000;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_UP   = 2'd1,
        ST_SERVE_DOWN = 2'd2,
        ST_DWELL      = 2'd3
    } state_t;

endpackage

// File: rtl/elevator_floor_select.sv
// Combinational LOOK lookups: nearest pending call above and below the car,
// plus whether a call is waiting at the car's own floor.
module floor_select
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = NUM_FLOORS_DEF,
    parameter int FLOOR_W    = FLOOR_W_DEF
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    car_floor,
    output logic                  floor_legal,
    output logic                  here_found,
    output logic [FLOOR_W-1:0]    above,
    output logic                  above_found,
    output logic [FLOOR_W-1:0]    below,
    output logic                  below_found
);

    // An out-of-range car floor matches nothing, so every flag stays low.
    always_comb begin
        floor_legal = ({1'b0, car_floor} < (FLOOR_W + 1)'(NUM_FLOORS));
        here_found  = 1'b0;
        above       = {FLOOR_W{1'b0}};
        above_found = 1'b0;
        below       = {FLOOR_W{1'b0}};
        below_found = 1'b0;
        // Scan downward so the last hit is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            above_found = above_found | (floor_legal && pending[i] && (FLOOR_W'(i) > car_floor));
            above       = (floor_legal && pending[i] && (FLOOR_W'(i) > car_floor)) ? FLOOR_W'(i) : above;
        end
        // Scan upward so the last hit is the highest floor below the car.
        for (int j = 0; j < NUM_FLOORS; j++) begin
            below_found = below_found | (floor_legal && pending[j] && (FLOOR_W'(j) < car_floor));
            below       = (floor_legal && pending[j] && (FLOOR_W'(j) < car_floor)) ? FLOOR_W'(j) : below;
            here_found  = here_found | (floor_legal && pending[j] && (FLOOR_W'(j) == car_floor));
        end
    end

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK scheduler: latches floor calls, steers the car controller through
// target_floor/target_valid and times the door dwell at each served floor.
module elevator_request_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS   = NUM_FLOORS_DEF,
    parameter int FLOOR_W      = FLOOR_W_DEF,
    parameter int DWELL_CYCLES = DWELL_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] req_pulse,
    input  logic [FLOOR_W-1:0]    car_floor,
    input  logic                  car_idle,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  target_valid,
    output logic                  door_open,
    output logic                  dir_up,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int CNT_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);

    state_t                  state_r;
    logic [NUM_FLOORS-1:0]   pending_r;
    logic [NUM_FLOORS-1:0]   clear_mask_s;
    logic [FLOOR_W-1:0]      target_floor_r;
    logic                    target_valid_r;
    logic                    door_open_r;
    logic                    dir_up_r;
    logic [CNT_W-1:0]        dwell_cnt_r;
    logic                    floor_legal_s;
    logic                    here_found_s;
    logic [FLOOR_W-1:0]      above_s;
    logic                    above_found_s;
    logic [FLOOR_W-1:0]      below_s;
    logic                    below_found_s;

    floor_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_floor_select (
        .pending     (pending_r),
        .car_floor   (car_floor),
        .floor_legal (floor_legal_s),
        .here_found  (here_found_s),
        .above       (above_s),
        .above_found (above_found_s),
        .below       (below_s),
        .below_found (below_found_s)
    );

    // Only the floor the doors are open at is cleared, so a call there during dwell is absorbed.
    always_comb begin
        clear_mask_s = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            clear_mask_s[i] = (state_r == ST_DWELL) && floor_legal_s && (car_floor == FLOOR_W'(i));
        end
    end

    // Outstanding-call bitmap; clear beats a simultaneous set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_r <= {NUM_FLOORS{1'b0}};
        end else begin
            pending_r <= (pending_r | req_pulse) & ~clear_mask_s;
        end
    end

    // Scheduler FSM with dwell counter and registered car-controller outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            target_floor_r <= {FLOOR_W{1'b0}};
            target_valid_r <= 1'b0;
            door_open_r    <= 1'b0;
            dir_up_r       <= 1'b1;
            dwell_cnt_r    <= {CNT_W{1'b0}};
        end else if (!floor_legal_s) begin
            state_r <= state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    target_valid_r <= 1'b0;
                    if (here_found_s) begin
                        state_r     <= ST_DWELL;
                        door_open_r <= 1'b1;
                        dwell_cnt_r <= {CNT_W{1'b0}};
                    end else if (above_found_s) begin
                        state_r        <= ST_SERVE_UP;
                        dir_up_r       <= 1'b1;
                        target_floor_r <= above_s;
                        target_valid_r <= 1'b1;
                    end else if (below_found_s) begin
                        state_r        <= ST_SERVE_DOWN;
                        dir_up_r       <= 1'b0;
                        target_floor_r <= below_s;
                        target_valid_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SERVE_UP: begin
                    if (car_idle && (car_floor == target_floor_r) && target_valid_r) begin
                        state_r        <= ST_DWELL;
                        target_valid_r <= 1'b0;
                        door_open_r    <= 1'b1;
                        dwell_cnt_r    <= {CNT_W{1'b0}};
                    end else if (above_found_s && (above_s < target_floor_r)) begin
                        target_floor_r <= above_s;
                        target_valid_r <= 1'b1;
                    end else begin
                        target_valid_r <= 1'b1;
                    end
                end
                ST_SERVE_DOWN: begin
                    if (car_idle && (car_floor == target_floor_r) && target_valid_r) begin
                        state_r        <= ST_DWELL;
                        target_valid_r <= 1'b0;
                        door_open_r    <= 1'b1;
                        dwell_cnt_r    <= {CNT_W{1'b0}};
                    end else if (below_found_s && (below_s > target_floor_r)) begin
                        target_floor_r <= below_s;
                        target_valid_r <= 1'b1;
                    end else begin
                        target_valid_r <= 1'b1;
                    end
                end
                ST_DWELL: begin
                    target_valid_r <= 1'b0;
                    if (dwell_cnt_r == DWELL_LAST) begin
                        door_open_r <= 1'b0;
                        dwell_cnt_r <= {CNT_W{1'b0}};
                        // Keep the sweep direction while calls lie ahead, otherwise reverse.
                        if ((dir_up_r && above_found_s) || (!dir_up_r && !below_found_s && above_found_s)) begin
                            state_r        <= ST_SERVE_UP;
                            dir_up_r       <= 1'b1;
                            target_floor_r <= above_s;
                            target_valid_r <= 1'b1;
                        end else if (below_found_s) begin
                            state_r        <= ST_SERVE_DOWN;
                            dir_up_r       <= 1'b0;
                            target_floor_r <= below_s;
                            target_valid_r <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        door_open_r <= 1'b1;
                        dwell_cnt_r <= dwell_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r        <= ST_IDLE;
                    target_valid_r <= 1'b0;
                    door_open_r    <= 1'b0;
                    dwell_cnt_r    <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign target_floor = target_floor_r;
    assign target_valid = target_valid_r;
    assign door_open    = door_open_r;
    assign dir_up       = dir_up_r;
    assign pending      = pending_r;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with a 4-cycle dwell.
module tb_elevator_request_scheduler;

    logic       clk;
    logic       reset;
    logic [9:0] req_pulse;
    logic [3:0] car_floor;
    logic       car_idle;
    logic [3:0] target_floor;
    logic       target_valid;
    logic       door_open;
    logic       dir_up;
    logic [9:0] pending;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    elevator_request_scheduler #(
        .NUM_FLOORS   (10),
        .FLOOR_W      (4),
        .DWELL_CYCLES (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_pulse    (req_pulse),
        .car_floor    (car_floor),
        .car_idle     (car_idle),
        .target_floor (target_floor),
        .target_valid (target_valid),
        .door_open    (door_open),
        .dir_up       (dir_up),
        .pending      (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Doors already open after the entry edge: expect 3 more open cycles, then closed.
    task automatic dwell_tail(input string tag);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk({tag, "_door_hi"}, 32'(door_open), 32'd1);
        end
        tick();
        chk({tag, "_door_lo"}, 32'(door_open), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        req_pulse = 10'd0;
        car_floor = 4'd0;
        car_idle  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        chk("rst_valid",   32'(target_valid), 32'd0);
        chk("rst_door",    32'(door_open),    32'd0);
        chk("rst_dir",     32'(dir_up),       32'd1);
        chk("rst_pending", 32'(pending),      32'd0);
        chk("rst_target",  32'(target_floor), 32'd0);

        // Single call to floor 3 from floor 0.
        req_pulse = 10'h008;
        tick();
        req_pulse = 10'd0;
        chk("f3_pending", 32'(pending),      32'h008);
        chk("f3_novalid", 32'(target_valid), 32'd0);
        tick();
        chk("f3_target",  32'(target_floor), 32'd3);
        chk("f3_valid",   32'(target_valid), 32'd1);
        chk("f3_dir",     32'(dir_up),       32'd1);
        car_floor = 4'd3;
        tick();
        chk("f3_door",    32'(door_open),    32'd1);
        chk("f3_dvalid",  32'(target_valid), 32'd0);
        dwell_tail("f3");
        chk("f3_cleared", 32'(pending),      32'd0);
        chk("f3_idle",    32'(target_valid), 32'd0);

        // Moving up from 2 to 7; floor 5 appears ahead, floor 1 behind.
        car_floor = 4'd2;
        car_idle  = 1'b0;
        req_pulse = 10'h080;
        tick();
        req_pulse = 10'd0;
        tick();
        chk("up_t7", 32'(target_floor), 32'd7);
        req_pulse = 10'h022;
        tick();
        req_pulse = 10'd0;
        chk("up_pend", 32'(pending), 32'h0A2);
        tick();
        chk("up_retarget5", 32'(target_floor), 32'd5);
        chk("up_dir",       32'(dir_up),       32'd1);
        car_floor = 4'd5;
        car_idle  = 1'b1;
        tick();
        chk("f5_door", 32'(door_open), 32'd1);
        dwell_tail("f5");
        chk("f5_next7",  32'(target_floor), 32'd7);
        chk("f5_valid",  32'(target_valid), 32'd1);
        chk("f5_pend",   32'(pending),      32'h082);
        car_floor = 4'd6;
        car_idle  = 1'b0;
        tick();
        chk("f6_pass_t7", 32'(target_floor), 32'd7);
        car_floor = 4'd7;
        car_idle  = 1'b1;
        tick();
        chk("f7_door", 32'(door_open), 32'd1);
        dwell_tail("f7");
        chk("rev_dir",    32'(dir_up),       32'd0);
        chk("rev_target", 32'(target_floor), 32'd1);
        chk("rev_valid",  32'(target_valid), 32'd1);
        chk("rev_pend",   32'(pending),      32'h002);
        car_floor = 4'd1;
        tick();
        chk("f1_door", 32'(door_open), 32'd1);
        dwell_tail("f1");
        chk("f1_pend",  32'(pending),      32'd0);
        chk("f1_dir",   32'(dir_up),       32'd0);
        chk("f1_valid", 32'(target_valid), 32'd0);

        // Illegal car floor: call latches but nothing is scheduled.
        car_floor = 4'd12;
        req_pulse = 10'h010;
        tick();
        req_pulse = 10'd0;
        tick();
        tick();
        chk("ill_valid", 32'(target_valid), 32'd0);
        chk("ill_door",  32'(door_open),    32'd0);
        chk("ill_pend",  32'(pending),      32'h010);

        // Car reaches 4: dwell, and a re-press of 4 is absorbed.
        car_floor = 4'd4;
        tick();
        chk("f4_door", 32'(door_open), 32'd1);
        chk("f4_pend", 32'(pending),   32'h010);
        req_pulse = 10'h010;
        tick();
        chk("f4_absorb1", 32'(pending),   32'd0);
        chk("f4_door1",   32'(door_open), 32'd1);
        tick();
        req_pulse = 10'd0;
        chk("f4_absorb2", 32'(pending),   32'd0);
        tick();
        chk("f4_door3",   32'(door_open), 32'd1);
        tick();
        chk("f4_closed",  32'(door_open), 32'd0);
        chk("f4_pend_end", 32'(pending),  32'd0);

        // Calls on both sides of floor 3: up wins.
        car_floor = 4'd3;
        req_pulse = 10'h042;
        tick();
        req_pulse = 10'd0;
        tick();
        chk("both_target", 32'(target_floor), 32'd6);
        chk("both_dir",    32'(dir_up),       32'd1);
        chk("both_valid",  32'(target_valid), 32'd1);

        // Reset mid-travel.
        #2;
        reset = 1'b1;
        #1;
        chk("mtr_valid", 32'(target_valid), 32'd0);
        chk("mtr_pend",  32'(pending),      32'd0);
        tick();
        reset = 1'b0;

        // Reset mid-dwell at 4 with floors 2 and 5 outstanding.
        car_floor = 4'd4;
        car_idle  = 1'b1;
        req_pulse = 10'h034;
        tick();
        req_pulse = 10'd0;
        tick();
        chk("md_door", 32'(door_open), 32'd1);
        tick();
        chk("md_pend", 32'(pending), 32'h024);
        #2;
        reset = 1'b1;
        #1;
        chk("md_rst_pend",   32'(pending),      32'd0);
        chk("md_rst_door",   32'(door_open),    32'd0);
        chk("md_rst_valid",  32'(target_valid), 32'd0);
        chk("md_rst_dir",    32'(dir_up),       32'd1);
        chk("md_rst_target", 32'(target_floor), 32'd0);
        tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("md_lost_pend",  32'(pending),      32'd0);
        chk("md_lost_valid", 32'(target_valid), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
